// File: rtl/parallel_axis_playback_if.sv
// AXI-Stream bundle carrying alpaca_data_pkt_axis beats from a source to a sink.
// Each beat is SAMP_PER_CLK samples in tdata; tlast/tuser mark frame boundaries.
interface parallel_axis_playback_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TUSER_W = 8
);
  logic [DATA_W-1:0]  tdata;
  logic               tvalid;
  logic               tready;
  logic               tlast;
  logic [TUSER_W-1:0] tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/parallel_axis_playback.sv
// Playback source: RAM preloaded through a write port, streamed out as framed AXIS beats.
// A one-beat prefetch register behind the output register gives gapless single-pass or looped playback.
module parallel_axis_playback #(
  parameter int unsigned SAMP_PER_CLK = 2,
  parameter int unsigned FRAME_LEN    = 8,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TUSER        = 8,
  parameter int unsigned SAMP_W       = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr_i,
  input  logic [SAMP_PER_CLK*SAMP_W-1:0]   wr_data_i,
  input  logic                             start_i,
  input  logic                             loop_en_i,
  input  logic                             stop_i,
  parallel_axis_playback_if.master         m_axis,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             wr_ignored_o,
  output logic [31:0]                      frames_sent_o
);

  localparam int unsigned DATA_W = SAMP_PER_CLK * SAMP_W;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned FL_W   = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  // prefetch stage: RAM read register
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic               rd_end_q, rd_end_d;

  // output stage
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               out_end_q, out_end_d;

  logic               loop_q, loop_d;
  logic               stop_pend_q, stop_pend_d;
  logic [TUSER-1:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]        frames_q, frames_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_ign_q, wr_ign_d;

  logic               xfer, slot_free, fetch, finish;

  // RAM only accepts writes while idle so a running playback is never corrupted
  always_ff @(posedge clk) begin
    if (wr_en_i && (state_q == S_IDLE)) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;
    rd_end_d    = rd_end_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    out_end_d   = out_end_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    frame_cnt_d = frame_cnt_q;
    frames_d    = frames_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_ign_d    = wr_en_i && (state_q != S_IDLE);
    fetch       = 1'b0;
    finish      = 1'b0;
    xfer        = tvalid_q && m_axis.tready;
    slot_free   = !tvalid_q || m_axis.tready;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_FETCH;
          busy_d      = 1'b1;
          rd_ptr_d    = '0;
          rd_valid_d  = 1'b0;
          frame_cnt_d = '0;
          loop_d      = loop_en_i;
          stop_pend_d = 1'b0;
        end
      end
      S_FETCH: begin
        state_d     = S_STREAM;
        stop_pend_d = stop_pend_q || stop_i;
        fetch       = 1'b1;
      end
      S_STREAM: begin
        stop_pend_d = stop_pend_q || stop_i;
        finish      = xfer && ((out_end_q && !loop_q) || (tlast_q && (stop_pend_q || stop_i)));
        // move prefetched beat into the output slot and refill behind it
        if (slot_free) begin
          if (rd_valid_q) begin
            tdata_d    = rd_data_q;
            tvalid_d   = 1'b1;
            tlast_d    = rd_last_q;
            out_end_d  = rd_end_q;
            fetch      = loop_q || !rd_end_q;
            rd_valid_d = fetch;
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end
        if (xfer && tlast_q) begin
          frame_cnt_d = frame_cnt_q + TUSER'(1);
          frames_d    = frames_q + 32'd1;
        end
        if (finish) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          tvalid_d   = 1'b0;
          tlast_d    = 1'b0;
          rd_valid_d = 1'b0;
          fetch      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fetch) begin
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
      rd_last_d  = (rd_ptr_q[FL_W-1:0] == FL_W'(FRAME_LEN - 1));
      rd_end_d   = (rd_ptr_q == AW'(DEPTH - 1));
      rd_ptr_d   = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_end_q    <= 1'b0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      out_end_q   <= 1'b0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      frame_cnt_q <= '0;
      frames_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ign_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_end_q    <= rd_end_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      out_end_q   <= out_end_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      frame_cnt_q <= frame_cnt_d;
      frames_q    <= frames_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_ign_q    <= wr_ign_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = frame_cnt_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign wr_ignored_o  = wr_ign_q;
  assign frames_sent_o = frames_q;

endmodule
